// File: rtl/seq_checker_if.sv
// Valid/ready stream carrying the words under check.
// The producer drives i_valid/i_data; the checker returns i_ready.
interface seq_checker_if #(
  parameter int DW = 4
);
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;

  modport master (
    output i_valid,
    output i_data,
    input  i_ready
  );

  modport slave (
    input  i_valid,
    input  i_data,
    output i_ready
  );
endinterface

// File: rtl/seq_checker.sv
// Burst checker: compares a stream against an incrementing sequence
// that starts at seed, reporting errors, first error index and timeout.
module seq_checker #(
  parameter int DW  = 4,
  parameter int LEN = 10,
  parameter int TMO = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] seed,
  seq_checker_if.slave  s,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          mismatch,
  output logic [7:0]    err_cnt,
  output logic [7:0]    first_err_idx,
  output logic          timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    FIN
  } state_e;

  localparam logic [7:0] NONE  = 8'hFF;
  localparam logic [7:0] LAST  = 8'(LEN - 1);
  localparam logic [7:0] TLAST = 8'(TMO - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] exp_q, exp_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    idle_q, idle_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    first_q, first_d;
  logic          tmo_q, tmo_d;
  logic          pass_q, pass_d;
  logic          mm_q, mm_d;

  logic ready;
  logic xfer;
  logic last;
  logic tmo_hit;

  assign xfer    = s.i_valid && (state_q == RUN);
  assign last    = (idx_q == LAST);
  assign tmo_hit = (state_q == RUN) && !xfer
                   && (idle_q == TLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A last transfer wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = ARM;
      ARM:  state_d = RUN;
      RUN: begin
        if (xfer && last) begin
          state_d = FIN;
        end else if (tmo_hit) begin
          state_d = FIN;
        end
      end
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      IDLE: ;
      ARM:  busy = 1'b1;
      RUN: begin
        busy  = 1'b1;
        ready = 1'b1;
      end
      FIN:  done = 1'b1;
      default: ;
    endcase
  end

  assign s.i_ready = ready;

  always_comb begin
    exp_d   = exp_q;
    idx_d   = idx_q;
    idle_d  = idle_q;
    err_d   = err_q;
    first_d = first_q;
    tmo_d   = tmo_q;
    pass_d  = pass_q;
    mm_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = seed;
          idx_d   = '0;
          idle_d  = '0;
          err_d   = '0;
          first_d = NONE;
          tmo_d   = 1'b0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (xfer) begin
          exp_d  = exp_q + DW'(1);
          idx_d  = idx_q + 8'd1;
          idle_d = '0;
          if (s.i_data != exp_q) begin
            mm_d = 1'b1;
            if (err_q != NONE) begin
              err_d = err_q + 8'd1;
            end
            if (first_q == NONE) begin
              first_d = idx_q;
            end
          end
        end else begin
          idle_d = idle_q + 8'd1;
          if (tmo_hit) begin
            tmo_d = 1'b1;
          end
        end
      end
      FIN: begin
        pass_d = (err_q == 8'd0) && !tmo_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q   <= '0;
      idx_q   <= '0;
      idle_q  <= '0;
      err_q   <= '0;
      first_q <= NONE;
      tmo_q   <= 1'b0;
      pass_q  <= 1'b0;
      mm_q    <= 1'b0;
    end else begin
      exp_q   <= exp_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      first_q <= first_d;
      tmo_q   <= tmo_d;
      pass_q  <= pass_d;
      mm_q    <= mm_d;
    end
  end

  assign pass          = pass_q;
  assign mismatch      = mm_q;
  assign err_cnt       = err_q;
  assign first_err_idx = first_q;
  assign timeout       = tmo_q;

endmodule

// File: tb/tb_seq_checker.sv
// Scenario bench for seq_checker: a reference model pushes expected
// mismatch flags per transfer, popped when the DUT answers.
module tb_seq_checker;

  localparam int LEN = 10;
  localparam int TMO = 16;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] seed;
  logic       busy;
  logic       done;
  logic       pass;
  logic       mismatch;
  logic [7:0] err_cnt;
  logic [7:0] first_err_idx;
  logic       timeout;

  seq_checker_if #(.DW(4)) bus ();

  seq_checker #(
    .DW (4),
    .LEN(LEN),
    .TMO(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .seed         (seed),
    .s            (bus),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .mismatch     (mismatch),
    .err_cnt      (err_cnt),
    .first_err_idx(first_err_idx),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  bit         stim_v[$];
  logic [3:0] stim_d[$];
  bit         sb_q[$];
  int         n_xfer;
  int         n_mm;
  int         start_at;
  bit         to_m;

  task automatic push_w(input bit v, input logic [3:0] d);
    stim_v.push_back(v);
    stim_d.push_back(d);
  endtask

  task automatic run_burst(input logic [3:0] sd);
    logic [3:0] exp_m;
    logic [3:0] d;
    int         idx_m;
    int         idle_m;
    int         c;
    bit         fin_m;
    bit         rdy_m;
    bit         xf;
    bit         v;
    bit         mexp;
    sb_q.delete();
    n_xfer = 0;
    n_mm   = 0;
    to_m   = 0;
    seed   = sd;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    exp_m  = sd;
    idx_m  = 0;
    idle_m = 0;
    fin_m  = 0;
    c      = 0;
    while (!fin_m && c < 100) begin
      v = 0;
      d = 4'd0;
      if (stim_v.size() > 0) begin
        v = stim_v.pop_front();
        d = stim_d.pop_front();
      end
      bus.i_valid = v;
      bus.i_data  = d;
      start = (c == start_at);
      seed  = 4'd5;
      rdy_m = (c >= 1);
      n_total++;
      if (bus.i_ready !== rdy_m) begin
        $display("FAIL ready c=%0d got %b want %b",
                 c, bus.i_ready, rdy_m);
      end else n_pass++;
      xf = v && rdy_m;
      if (xf) begin
        sb_q.push_back(d !== exp_m);
        exp_m = exp_m + 4'd1;
        idle_m = 0;
        n_xfer++;
        if (idx_m == LEN - 1) fin_m = 1;
        idx_m++;
      end else if (rdy_m) begin
        idle_m++;
        if (idle_m == TMO) begin
          fin_m = 1;
          to_m  = 1;
        end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      mexp = 0;
      if (xf) mexp = sb_q.pop_front();
      if (mismatch === 1'b1) n_mm++;
      n_total++;
      if (mismatch !== mexp) begin
        $display("FAIL mismatch c=%0d got %b want %b",
                 c, mismatch, mexp);
      end else n_pass++;
      n_total++;
      if (done !== fin_m) begin
        $display("FAIL done c=%0d got %b want %b",
                 c, done, fin_m);
      end else n_pass++;
      c++;
    end
    if (!fin_m) begin
      n_total++;
      $display("FAIL burst_bound got no end want end");
    end
    stim_v.delete();
    stim_d.delete();
    bus.i_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string nm,
                              input bit p, input int e,
                              input int f, input bit t);
    n_total++;
    if (pass !== p) $display("FAIL %s pass got %b want %b", nm, pass, p);
    else n_pass++;
    n_total++;
    if (err_cnt !== 8'(e))
      $display("FAIL %s err_cnt got %0d want %0d", nm, err_cnt, e);
    else n_pass++;
    n_total++;
    if (first_err_idx !== 8'(f))
      $display("FAIL %s first got %0d want %0d", nm, first_err_idx, f);
    else n_pass++;
    n_total++;
    if (timeout !== t)
      $display("FAIL %s timeout got %b want %b", nm, timeout, t);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s idle got busy=%b done=%b want 0", nm, busy, done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    seed = 4'd0;
    bus.i_valid = 1'b0;
    bus.i_data = 4'd0;
    start_at = -1;
    #3;
    n_total++;
    if ({busy, done, pass, mismatch, timeout, bus.i_ready} !== 6'b0)
      $display("FAIL reset_flags got %b want 000000",
               {busy, done, pass, mismatch, timeout, bus.i_ready});
    else n_pass++;
    n_total++;
    if (err_cnt !== 8'd0 || first_err_idx !== 8'hFF)
      $display("FAIL reset_cnt got %0d/%0d want 0/255",
               err_cnt, first_err_idx);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_clean();
    for (int k = 0; k < 10; k++) push_w(1, 4'(k));
    push_w(0, 4'd0);
    stim_v.push_front(0);
    stim_d.push_front(4'd0);
    run_burst(4'd0);
    check_result("clean", 1, 0, 255, 0);
    n_total++;
    if (n_xfer != 10 || n_mm != 0)
      $display("FAIL clean_xfer got %0d/%0d want 10/0", n_xfer, n_mm);
    else n_pass++;
  endtask

  task automatic test_wrap();
    push_w(0, 4'd0);
    for (int k = 0; k < 10; k++) push_w(1, 4'(12 + k));
    run_burst(4'd12);
    check_result("wrap", 1, 0, 255, 0);
  endtask

  task automatic test_errors();
    logic [3:0] w;
    push_w(0, 4'd0);
    for (int k = 0; k < 10; k++) begin
      w = 4'(k);
      if (k == 3) w = 4'd7;
      if (k == 6) w = 4'd0;
      push_w(1, w);
    end
    start_at = 4;
    run_burst(4'd0);
    start_at = -1;
    check_result("errors", 0, 2, 3, 0);
    n_total++;
    if (n_mm != 2) $display("FAIL errors_pulses got %0d want 2", n_mm);
    else n_pass++;
  endtask

  task automatic test_timeout();
    push_w(0, 4'd0);
    for (int k = 0; k < 4; k++) push_w(1, 4'(k));
    run_burst(4'd0);
    check_result("timeout", 0, 0, 255, 1);
    n_total++;
    if (to_m !== 1'b1 || n_xfer != 4)
      $display("FAIL timeout_model got %b/%0d want 1/4", to_m, n_xfer);
    else n_pass++;
  endtask

  task automatic test_stall_resume();
    push_w(0, 4'd0);
    for (int k = 0; k < 4; k++) push_w(1, 4'(k));
    for (int k = 0; k < 15; k++) push_w(0, 4'(k + 2));
    for (int k = 4; k < 10; k++) push_w(1, 4'(k));
    run_burst(4'd0);
    check_result("stall15", 1, 0, 255, 0);
  endtask

  task automatic test_back_to_back();
    push_w(1, 4'd9);
    for (int k = 0; k < 14; k++) push_w(1, 4'(k));
    run_burst(4'd0);
    check_result("backpress", 1, 0, 255, 0);
    n_total++;
    if (n_xfer != 10) $display("FAIL bp_xfer got %0d want 10", n_xfer);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    seed = 4'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data = (k == 2) ? 4'd9 : 4'(k);
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    n_total++;
    if (err_cnt !== 8'd1 || busy !== 1'b1)
      $display("FAIL pre_rst got %0d/%b want 1/1", err_cnt, busy);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if ({busy, done, bus.i_ready, mismatch, timeout, pass} !== 6'b0)
      $display("FAIL async_flags got %b want 000000",
               {busy, done, bus.i_ready, mismatch, timeout, pass});
    else n_pass++;
    n_total++;
    if (err_cnt !== 8'd0 || first_err_idx !== 8'hFF)
      $display("FAIL async_cnt got %0d/%0d want 0/255",
               err_cnt, first_err_idx);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done);
      else n_pass++;
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (busy !== 1'b0 || done !== 1'b0)
        $display("FAIL post_rst_idle got %b/%b want 0/0", busy, done);
      else n_pass++;
    end
    push_w(0, 4'd0);
    for (int k = 0; k < 10; k++) push_w(1, 4'(3 + k));
    run_burst(4'd3);
    check_result("after_rst", 1, 0, 255, 0);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_wrap();
    test_errors();
    test_timeout();
    test_stall_resume();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 SHALL have parameter DW, default 4, width of the checked data word.
REQ-002 SHALL have parameter LEN, default 10, number of words per checked burst (1..255).
REQ-003 SHALL have parameter TMO, default 16, idle cycles in RUN before timeout (1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to arm a burst check.
REQ-007 SHALL have port seed  input  DW  first expected value, sampled when start is accepted.
REQ-008 SHALL have port i_valid  input  1  producer offers i_data this cycle.
REQ-009 SHALL have port i_ready  output  1  checker accepts i_data this cycle.
REQ-010 SHALL have port i_data  input  DW  word under check.
REQ-011 SHALL have port busy  output  1  high in ARM or RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a burst check finishes.
REQ-013 SHALL have port pass  output  1  result of the last finished burst, held until the next start.
REQ-014 SHALL have port mismatch  output  1  one-cycle pulse on each accepted word that differs from the expected value.
REQ-015 SHALL have port err_cnt  output  8  mismatches in the current or last burst, saturating at 255.
REQ-016 SHALL have port first_err_idx  output  8  index (0-based) of the first mismatch; 255 if none.
REQ-017 SHALL have port timeout  output  1  sticky flag: last burst ended by timeout.

Function
REQ-018 SHALL implement the FSM states IDLE, ARM, RUN, and FIN.
REQ-019 IDLE: start=1 SHALL load exp<=seed, idx<=0, err_cnt<=0, first_err_idx<=255, timeout<=0, pass<=0, and SHALL move to ARM.
REQ-020 ARM SHALL last exactly one cycle with i_ready=0, then SHALL move to RUN.
REQ-021 RUN SHALL drive i_ready=1; a transfer occurs only when i_valid and i_ready are both 1.
REQ-022 On a transfer, the checker SHALL compare i_data with exp; on inequality it SHALL pulse mismatch in the next cycle, increment err_cnt (saturating), and set first_err_idx<=idx if it is 255.
REQ-023 On a transfer, exp SHALL advance to exp+1 modulo 2^DW (15 wraps to 0 for DW=4) and idx SHALL increment.
REQ-024 After the transfer with idx=LEN-1, the checker SHALL move to FIN; i_ready SHALL be 0 from the next cycle.
REQ-025 In RUN, the idle counter SHALL clear on a transfer and increment on any cycle without one.
REQ-026 When the idle counter reaches TMO, the checker SHALL set timeout=1 and move to FIN.
REQ-027 FIN SHALL last one cycle, pulse done, set pass=(err_cnt==0 && !timeout), and return to IDLE.
REQ-028 The latency from start to the first possible transfer SHALL be 2 cycles; the latency from the last transfer to done SHALL be 1 cycle.
REQ-029 start SHALL be ignored in ARM, RUN, and FIN; no restart mid-burst.
REQ-030 A simultaneous last transfer and timeout condition SHALL count as a completed burst (timeout=0).
REQ-031 err_cnt, first_err_idx, pass, and timeout SHALL hold their values in IDLE until the next accepted start.
REQ-032 i_data SHALL be ignored whenever no transfer occurs.

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE, i_ready=0, busy=0, done=0, pass=0, mismatch=0, err_cnt=0, first_err_idx=255, timeout=0, exp=0, idx=0, and idle counter=0.
REQ-034 Reset asserted mid-burst SHALL abandon the burst with no done pulse; after release, the checker SHALL wait in IDLE for start.

Verification
REQ-035 Clean burst: seed=0, start, 10 consecutive valid words 0..9 -> done 1 cycle after word 9, pass=1, err_cnt=0, first_err_idx=255.
REQ-036 Wrap: seed=12, words 12,13,14,15,0,1,2,3,4,5 -> pass=1.
REQ-037 Errors: seed=0, words with index 3 =7 and index 6 =0 -> two mismatch pulses, err_cnt=2, first_err_idx=3, pass=0.
REQ-038 Stall/timeout: 4 good words, then i_valid=0 for 16 cycles -> timeout=1, done pulse, pass=0; with 15 idle cycles then resumed good words -> pass=1.
REQ-039 Backpressure: i_valid held high from start onward -> no transfer counted during the ARM cycle, and exactly 10 transfers occur.
REQ-040 Async reset in RUN after word 5 -> outputs take reset values immediately with no done pulse; a new start then runs a clean burst that ends with pass=1.
